alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter DIV_STEPS, default 32, number of divider advance cycles per divide (legal range 2..63).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous, active-high reset (asserted = 1), sampled on rising clk.
REQ-004 issue  input  1  pipeline presents an ALU op this cycle.
REQ-005 ALUop  input  21  one-hot op vector; bits 10-13 = mul/mulh/mulhsu/mulhu, bits 14-17 = div/divu/rem/remu.
REQ-006 flush  input  1  pipeline kill; aborts any multi-cycle op.
REQ-007 mul_state  output  2  multiplier phase control to the ALU.
REQ-008 d_init  output  1  divider operand-load strobe.
REQ-009 d_advance  output  1  divider step enable.
REQ-010 div_last  output  1  marks final divider step.
REQ-011 stall  output  1  pipeline must hold ALU operands and ALUop.
REQ-012 done  output  1  one-cycle pulse; ALU result valid this cycle.
REQ-013 busy  output  1  registered; 1 while state is not IDLE.

Function
REQ-014 States SHALL be IDLE, MUL, DIV; a 6-bit step counter cnt is used in MUL and DIV.
REQ-015 mul_issue = issue & |ALUop[13:10]; div_issue = issue & |ALUop[17:14]; both set is illegal, mul SHALL win.
REQ-016 In IDLE, outputs SHALL be Mealy-decoded from inputs; in MUL/DIV, from state and cnt only.
REQ-017 IDLE, mul_issue & ~flush (cycle T): mul_state=01, stall=1; next state MUL, cnt=1.
REQ-018 MUL, cnt=1 (T+1): mul_state=10, stall=1; cnt<=2.
REQ-019 MUL, cnt=2 (T+2): mul_state=11, stall=0, done=1; next state IDLE.
REQ-020 IDLE, div_issue & ~flush (cycle T): d_init=1, stall=1; next state DIV, cnt=1.
REQ-021 DIV, cnt=k, 1<=k<DIV_STEPS: d_advance=1, stall=1; cnt<=k+1.
REQ-022 DIV, cnt=DIV_STEPS (T+DIV_STEPS): d_advance=1, div_last=1, stall=0, done=1; next state IDLE.
REQ-023 Multiply latency SHALL be 3 cycles incl. issue; divide latency DIV_STEPS+1 cycles incl. issue.
REQ-024 Issue of any non-mul/div op, or no issue, in IDLE: all outputs 0, state unchanged.
REQ-025 issue while in MUL/DIV SHALL be ignored (pipeline is stalled holding the same op).
REQ-026 A new op MAY issue in the cycle following done (back-to-back), with no idle bubble required.
REQ-027 flush=1 in any state SHALL force all Mealy outputs to 0 that cycle (mul_state=00, no strobes, stall=0, done=0) and next state IDLE, cnt=0.
REQ-028 flush and issue in the same IDLE cycle: flush wins, no op started.
REQ-029 flush on the done cycle: done suppressed, result discarded.
REQ-030 d_init, d_advance, done SHALL never be high in the same cycle; mul_state SHALL be 00 whenever not in a multiply.
REQ-031 cnt SHALL never exceed DIV_STEPS; no wrap-around.

Reset
REQ-032 resetn=1 at a rising edge SHALL set state=IDLE, cnt=0, busy=0.
REQ-033 While resetn=1, all outputs SHALL be 0 regardless of issue/flush.
REQ-034 Reset mid-operation SHALL abort identically to flush; first cycle after reset deassertion behaves as IDLE.

Verification
REQ-035 mul issue at T -> mul_state 01,10,11 at T,T+1,T+2; stall 1,1,0; done only at T+2; busy=1 at T+1,T+2.
REQ-036 divu issue at T (DIV_STEPS=32) -> d_init at T; d_advance T+1..T+32; div_last and done only at T+32; stall low at T+32.
REQ-037 flush at T+10 of divide -> all outputs 0 at T+10, busy=0 at T+11; a mul issued at T+11 completes at T+13.
REQ-038 add op (ALUop[0]) with issue -> no stall, no strobes, state stays IDLE.
REQ-039 mul done at T+2 followed by rem issue at T+3 -> d_init at T+3, done at T+35.
REQ-040 resetn asserted at T+1 of multiply -> all outputs 0 during reset, busy=0 after, no done pulse.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Pipeline <-> ALU sequencer bundle: op issue/kill from the pipeline and the
// multiplier/divider phase controls, stall and completion back to it.
interface alu_seq_ctrl_if;
   logic        issue;
   logic [20:0] ALUop;
   logic        flush;
   logic [1:0]  mul_state;
   logic        d_init;
   logic        d_advance;
   logic        div_last;
   logic        stall;
   logic        done;
   logic        busy;

   // Pipeline side: presents ops, receives sequencing controls.
   modport master (
      output issue, ALUop, flush,
      input  mul_state, d_init, d_advance, div_last, stall, done, busy
   );

   // Sequencer side.
   modport slave (
      input  issue, ALUop, flush,
      output mul_state, d_init, d_advance, div_last, stall, done, busy
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: steps a 3-cycle multiplier and a
// (DIV_STEPS+1)-cycle divider, stalling the pipeline until the result is ready.
//
// state | meaning
// IDLE  | no multi-cycle op; outputs decoded from the incoming op
// MUL   | multiply in flight, cnt = cycles since issue (1..2)
// DIV   | divide in flight, cnt = divider step number (1..DIV_STEPS)
//
// resetn is active-high despite its name. Reset and flush both kill the
// in-flight op and zero every output in the cycle they are seen.
module alu_seq_ctrl #(
   parameter int unsigned DIV_STEPS = 32
) (
   input logic            clk,
   input logic            resetn,
   alu_seq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   localparam logic [5:0] CNT_LAST = 6'(DIV_STEPS);
   localparam logic [5:0] MUL_LAST = 6'd2;

   state_t     state;
   logic [5:0] cnt;
   logic       busy_q;
   logic       mul_issue;
   logic       div_issue;

   // Multiply takes priority when a malformed op sets both groups.
   always_comb begin
      mul_issue = bus.issue & (|bus.ALUop[13:10]);
      div_issue = bus.issue & (|bus.ALUop[17:14]) & ~mul_issue;
   end

   // State, step counter and busy flag; issue is ignored outside IDLE.
   always_ff @(posedge clk) begin
      if (resetn || bus.flush) begin
         state  <= IDLE;
         cnt    <= 6'd0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mul_issue) begin
                  state  <= MUL;
                  cnt    <= 6'd1;
                  busy_q <= 1'b1;
               end else if (div_issue) begin
                  state  <= DIV;
                  cnt    <= 6'd1;
                  busy_q <= 1'b1;
               end
            end
            MUL: begin
               if (cnt >= MUL_LAST) begin
                  state  <= IDLE;
                  cnt    <= 6'd0;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            DIV: begin
               if (cnt >= CNT_LAST) begin
                  state  <= IDLE;
                  cnt    <= 6'd0;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= 6'd0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Output decode: from the op in IDLE, from state/cnt while an op is in flight.
   always_comb begin
      bus.mul_state = 2'b00;
      bus.d_init    = 1'b0;
      bus.d_advance = 1'b0;
      bus.div_last  = 1'b0;
      bus.stall     = 1'b0;
      bus.done      = 1'b0;
      if (!resetn && !bus.flush) begin
         case (state)
            IDLE: begin
               if (mul_issue) begin
                  bus.mul_state = 2'b01;
                  bus.stall     = 1'b1;
               end else if (div_issue) begin
                  bus.d_init = 1'b1;
                  bus.stall  = 1'b1;
               end
            end
            MUL: begin
               if (cnt == 6'd1) begin
                  bus.mul_state = 2'b10;
                  bus.stall     = 1'b1;
               end else if (cnt == MUL_LAST) begin
                  bus.mul_state = 2'b11;
                  bus.done      = 1'b1;
               end
            end
            DIV: begin
               if (cnt == CNT_LAST) begin
                  bus.d_advance = 1'b1;
                  bus.div_last  = 1'b1;
                  bus.done      = 1'b1;
               end else if (cnt != 6'd0) begin
                  bus.d_advance = 1'b1;
                  bus.stall     = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // busy is the registered in-flight flag, held low while reset is applied.
   always_comb begin
      bus.busy = busy_q & ~resetn;
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed op sequences, a latency-based reference
// model checked every cycle, and literal spot checks on key cycles.
module tb_alu_seq_ctrl;
   localparam int unsigned DIV_STEPS = 32;

   localparam logic [20:0] OP_NONE = 21'h0;
   localparam logic [20:0] OP_ADD  = 21'h1;
   localparam logic [20:0] OP_MUL  = 21'h1 << 10;
   localparam logic [20:0] OP_DIVU = 21'h1 << 15;
   localparam logic [20:0] OP_REM  = 21'h1 << 16;

   logic clk;
   logic resetn;
   int   n_chk  = 0;
   int   n_fail = 0;

   alu_seq_ctrl_if bus ();

   alu_seq_ctrl #(.DIV_STEPS(DIV_STEPS)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: an op in flight is described by its kind and the cycle it issued;
   // expected outputs follow from the age of the op.
   int  cyc      = 0;
   bit  m_active = 0;
   bit  m_div    = 0;
   int  m_t0     = 0;

   // Every negedge: compare DUT against the model, then advance the model.
   always @(negedge clk) begin
      logic [1:0] e_ms;
      logic e_init, e_adv, e_last, e_stall, e_done, e_busy;
      bit   mi, di;
      int   age;
      e_ms = 2'b00; e_init = 0; e_adv = 0; e_last = 0; e_stall = 0; e_done = 0;
      e_busy = m_active && !resetn;
      mi  = bus.issue && (bus.ALUop[13:10] != 4'b0);
      di  = bus.issue && (bus.ALUop[17:14] != 4'b0) && !mi;
      age = cyc - m_t0;
      if (resetn === 1'b1 || bus.flush === 1'b1) begin
         m_active = 0;
      end else if (!m_active) begin
         if (mi) begin
            e_ms = 2'b01; e_stall = 1; m_active = 1; m_div = 0; m_t0 = cyc;
         end else if (di) begin
            e_init = 1; e_stall = 1; m_active = 1; m_div = 1; m_t0 = cyc;
         end
      end else if (!m_div) begin
         if (age == 1) begin
            e_ms = 2'b10; e_stall = 1;
         end else begin
            e_ms = 2'b11; e_done = 1; m_active = 0;
         end
      end else begin
         e_adv = 1;
         if (age >= int'(DIV_STEPS)) begin
            e_last = 1; e_done = 1; m_active = 0;
         end else begin
            e_stall = 1;
         end
      end
      chk("mul_state", 32'(bus.mul_state), 32'(e_ms));
      chk("d_init",    32'(bus.d_init),    32'(e_init));
      chk("d_advance", 32'(bus.d_advance), 32'(e_adv));
      chk("div_last",  32'(bus.div_last),  32'(e_last));
      chk("stall",     32'(bus.stall),     32'(e_stall));
      chk("done",      32'(bus.done),      32'(e_done));
      chk("busy",      32'(bus.busy),      32'(e_busy));
      cyc++;
   end

   task automatic drive(input bit iss, input logic [20:0] op, input bit fl, input bit rst);
      @(posedge clk);
      #1;
      bus.issue = iss;
      bus.ALUop = op;
      bus.flush = fl;
      resetn    = rst;
   endtask

   // Hold a divide op until done; returns cycles after issue and advance count.
   task automatic run_div(input logic [20:0] op, output int done_age, output int n_adv);
      done_age = -1;
      n_adv    = 0;
      for (int k = 1; k <= 40; k++) begin
         drive(1, op, 0, 0);
         @(negedge clk);
         if (bus.d_advance === 1'b1) n_adv++;
         if (bus.done === 1'b1) begin
            done_age = k;
            chk("div_done_stall", 32'(bus.stall), 32'd0);
            chk("div_done_last",  32'(bus.div_last), 32'd1);
            break;
         end
      end
   endtask

   initial begin
      int age, adv;
      bus.issue = 0; bus.ALUop = OP_NONE; bus.flush = 0; resetn = 1;

      // Reset: outputs quiet even with an op presented.
      drive(0, OP_NONE, 0, 1);
      drive(0, OP_NONE, 0, 1);
      drive(1, OP_MUL, 0, 1);
      @(negedge clk);
      chk("rst_ms", 32'(bus.mul_state), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      drive(0, OP_NONE, 0, 0);

      // Multiply: 01,10,11 with stall 1,1,0 and done on the third cycle.
      drive(1, OP_MUL, 0, 0);
      @(negedge clk);
      chk("mul_t0_ms", 32'(bus.mul_state), 32'd1);
      chk("mul_t0_busy", 32'(bus.busy), 32'd0);
      drive(1, OP_MUL, 0, 0);
      @(negedge clk);
      chk("mul_t1_ms", 32'(bus.mul_state), 32'd2);
      chk("mul_t1_busy", 32'(bus.busy), 32'd1);
      drive(1, OP_MUL, 0, 0);
      @(negedge clk);
      chk("mul_t2_ms", 32'(bus.mul_state), 32'd3);
      chk("mul_t2_done", 32'(bus.done), 32'd1);
      chk("mul_t2_stall", 32'(bus.stall), 32'd0);
      drive(0, OP_NONE, 0, 0);
      @(negedge clk);
      chk("mul_after_busy", 32'(bus.busy), 32'd0);

      // Single-cycle op: nothing happens.
      drive(1, OP_ADD, 0, 0);
      @(negedge clk);
      chk("add_stall", 32'(bus.stall), 32'd0);
      drive(0, OP_NONE, 0, 0);
      @(negedge clk);
      chk("add_busy", 32'(bus.busy), 32'd0);

      // Unsigned divide: done DIV_STEPS cycles after issue, advancing each one.
      drive(1, OP_DIVU, 0, 0);
      @(negedge clk);
      chk("divu_init", 32'(bus.d_init), 32'd1);
      run_div(OP_DIVU, age, adv);
      chk("divu_latency", 32'(age), 32'd32);
      chk("divu_advances", 32'(adv), 32'd32);
      drive(0, OP_NONE, 0, 0);

      // Flush at T+10 of a divide, then a multiply at T+11 completing at T+13.
      drive(1, OP_DIVU, 0, 0);
      for (int k = 1; k <= 9; k++) drive(1, OP_DIVU, 0, 0);
      drive(1, OP_DIVU, 1, 0);
      @(negedge clk);
      chk("flush_adv", 32'(bus.d_advance), 32'd0);
      chk("flush_stall", 32'(bus.stall), 32'd0);
      drive(1, OP_MUL, 0, 0);
      @(negedge clk);
      chk("flush_next_busy", 32'(bus.busy), 32'd0);
      chk("flush_next_ms", 32'(bus.mul_state), 32'd1);
      drive(1, OP_MUL, 0, 0);
      drive(1, OP_MUL, 0, 0);
      @(negedge clk);
      chk("flush_mul_done", 32'(bus.done), 32'd1);

      // Back-to-back: rem right after multiply done, done 32 cycles later.
      drive(1, OP_REM, 0, 0);
      @(negedge clk);
      chk("b2b_init", 32'(bus.d_init), 32'd1);
      chk("b2b_busy", 32'(bus.busy), 32'd0);
      run_div(OP_REM, age, adv);
      chk("rem_latency", 32'(age), 32'd32);
      drive(0, OP_NONE, 0, 0);

      // Reset at T+1 of a multiply: quiet, no done pulse afterwards.
      drive(1, OP_MUL, 0, 0);
      drive(1, OP_MUL, 0, 1);
      @(negedge clk);
      chk("rstmid_ms", 32'(bus.mul_state), 32'd0);
      chk("rstmid_busy", 32'(bus.busy), 32'd0);
      for (int k = 0; k < 3; k++) begin
         drive(0, OP_NONE, 0, 0);
         @(negedge clk);
         chk("rstmid_done", 32'(bus.done), 32'd0);
      end

      // Flush on the done cycle suppresses done.
      drive(1, OP_MUL, 0, 0);
      drive(1, OP_MUL, 0, 0);
      drive(1, OP_MUL, 1, 0);
      @(negedge clk);
      chk("flushdone_done", 32'(bus.done), 32'd0);
      chk("flushdone_ms", 32'(bus.mul_state), 32'd0);
      drive(0, OP_NONE, 0, 0);

      // Both op groups set: multiply wins.
      drive(1, OP_MUL | OP_DIVU, 0, 0);
      @(negedge clk);
      chk("both_ms", 32'(bus.mul_state), 32'd1);
      chk("both_init", 32'(bus.d_init), 32'd0);
      drive(1, OP_MUL | OP_DIVU, 0, 0);
      drive(1, OP_MUL | OP_DIVU, 0, 0);

      // A different op presented mid-multiply is ignored.
      drive(1, OP_MUL, 0, 0);
      drive(1, OP_DIVU, 0, 0);
      drive(1, OP_DIVU, 0, 0);
      @(negedge clk);
      chk("ignore_done", 32'(bus.done), 32'd1);
      chk("ignore_init", 32'(bus.d_init), 32'd0);
      drive(0, OP_NONE, 0, 0);
      drive(0, OP_NONE, 0, 0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
